// File: rtl/vidbuf_pkg.sv
// Shared definitions for the double-buffered video frame buffer:
// controller states and default geometry/colour settings.
package vidbuf_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CLEAR     = 2'd1,
    SWAP_WAIT = 2'd2
  } state_t;

  localparam int X_W_DEF   = 9;
  localparam int Y_W_DEF   = 8;
  localparam int PIX_W_DEF = 24;

  localparam logic [23:0] BORDER_DEF = 24'h000000;

endpackage

// File: rtl/vidbuf_ram.sv
// Single-clock simple dual-port RAM with a registered read port.
// Reading and writing the same word in one cycle returns the old contents.
module vidbuf_ram #(
  parameter int addr_width = 18,
  parameter int data_width = 24
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [addr_width-1:0] waddr,
  input  logic [data_width-1:0] wdata,
  input  logic [addr_width-1:0] raddr,
  output logic [data_width-1:0] q
);

  logic [data_width-1:0] mem_r [2**addr_width];

  // Storage write and registered read; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
    q <= mem_r[raddr];
  end

endmodule

// File: rtl/vidbuf_dbl.sv
// Double-buffered frame buffer: the writer fills the back frame while the
// scan reads the front frame; front/back swap only at the scan origin.
module vidbuf_dbl
  import vidbuf_pkg::*;
#(
  parameter int              X_W    = X_W_DEF,
  parameter int              Y_W    = Y_W_DEF,
  parameter int              PIX_W  = PIX_W_DEF,
  parameter int              COL_W  = 11,
  parameter int              ROW_W  = 10,
  parameter int              SCALE  = 0,
  parameter logic [PIX_W-1:0] BORDER = PIX_W'(BORDER_DEF)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [ROW_W-1:0]   ROW,
  input  logic [COL_W-1:0]   COL,
  output logic [PIX_W/3-1:0] R,
  output logic [PIX_W/3-1:0] G,
  output logic [PIX_W/3-1:0] B,
  input  logic [X_W-1:0]     wr_x,
  input  logic [Y_W-1:0]     wr_y,
  input  logic [PIX_W-1:0]   wr_data,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic               clr_req,
  input  logic [PIX_W-1:0]   clr_data,
  input  logic               swap_req,
  output logic               swap_ack,
  output logic               busy,
  output logic               front
);

  localparam int A_W  = X_W + Y_W;
  localparam int CH_W = PIX_W / 3;

  state_t             state_r, state_nx_s;
  logic [A_W-1:0]     cnt_r;
  logic [PIX_W-1:0]   clr_col_r;
  logic               swap_pend_r;
  logic               front_r, swap_ack_r, wr_ready_r, busy_r;
  logic               swap_fire_s, ld_clear_s, set_pend_s;
  logic               at_origin_s, cnt_last_s;

  logic               ram_we_s;
  logic [A_W:0]       ram_waddr_s, ram_raddr_s;
  logic [PIX_W-1:0]   ram_wdata_s, ram_q_s;
  logic [X_W-1:0]     rx_s;
  logic [Y_W-1:0]     ry_s;
  logic               vis_s, vis_r;
  logic [PIX_W-1:0]   rgb_r;

  assign at_origin_s = (ROW == {ROW_W{1'b0}}) && (COL == {COL_W{1'b0}});
  assign cnt_last_s  = (cnt_r == {A_W{1'b1}});

  // Controller next-state logic and one-cycle action strobes.
  always_comb begin
    state_nx_s  = state_r;
    swap_fire_s = 1'b0;
    ld_clear_s  = 1'b0;
    set_pend_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (clr_req) begin
          ld_clear_s = 1'b1;
          set_pend_s = swap_req;
          state_nx_s = CLEAR;
        end else if (swap_req) begin
          state_nx_s = SWAP_WAIT;
        end else begin
          state_nx_s = IDLE;
        end
      end
      CLEAR: begin
        if (cnt_last_s) begin
          state_nx_s = swap_pend_r ? SWAP_WAIT : IDLE;
        end else begin
          state_nx_s = CLEAR;
        end
      end
      SWAP_WAIT: begin
        if (at_origin_s) begin
          swap_fire_s = 1'b1;
          state_nx_s  = IDLE;
        end else begin
          state_nx_s = SWAP_WAIT;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Controller state, clear bookkeeping and registered status outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r     <= IDLE;
      cnt_r       <= {A_W{1'b0}};
      clr_col_r   <= {PIX_W{1'b0}};
      swap_pend_r <= 1'b0;
      front_r     <= 1'b0;
      swap_ack_r  <= 1'b0;
      wr_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      wr_ready_r <= (state_nx_s == IDLE);
      busy_r     <= (state_nx_s != IDLE);
      swap_ack_r <= swap_fire_s;
      if (swap_fire_s) begin
        front_r <= ~front_r;
      end
      if (ld_clear_s) begin
        clr_col_r <= clr_data;
        cnt_r     <= {A_W{1'b0}};
      end else if (state_r == CLEAR) begin
        cnt_r <= cnt_r + {{(A_W-1){1'b0}}, 1'b1};
      end
      if (ld_clear_s) begin
        swap_pend_r <= set_pend_s;
      end else if ((state_r == CLEAR) && cnt_last_s) begin
        swap_pend_r <= 1'b0;
      end
    end
  end

  // Write port mux: the clear engine owns the port while clearing.
  always_comb begin
    ram_we_s    = 1'b0;
    ram_waddr_s = {~front_r, wr_y, wr_x};
    ram_wdata_s = wr_data;
    if (state_r == CLEAR) begin
      ram_we_s    = 1'b1;
      ram_waddr_s = {~front_r, cnt_r};
      ram_wdata_s = clr_col_r;
    end else if (wr_valid && wr_ready_r) begin
      ram_we_s = 1'b1;
    end else begin
      ram_we_s = 1'b0;
    end
  end

  assign rx_s        = X_W'(COL >> SCALE);
  assign ry_s        = Y_W'(ROW >> SCALE);
  assign ram_raddr_s = {front_r, ry_s, rx_s};
  assign vis_s       = ((COL >> (X_W + SCALE)) == {COL_W{1'b0}}) &&
                       ((ROW >> (Y_W + SCALE)) == {ROW_W{1'b0}});

  vidbuf_ram #(
    .addr_width (A_W + 1),
    .data_width (PIX_W)
  ) u_ram (
    .clk   (CLK),
    .we    (ram_we_s),
    .waddr (ram_waddr_s),
    .wdata (ram_wdata_s),
    .raddr (ram_raddr_s),
    .q     (ram_q_s)
  );

  // Read pipeline: align the visible flag with RAM data, then register RGB.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      vis_r <= 1'b0;
      rgb_r <= {PIX_W{1'b0}};
    end else begin
      vis_r <= vis_s;
      rgb_r <= vis_r ? ram_q_s : BORDER;
    end
  end

  assign R        = rgb_r[3*CH_W-1:2*CH_W];
  assign G        = rgb_r[2*CH_W-1:CH_W];
  assign B        = rgb_r[CH_W-1:0];
  assign wr_ready = wr_ready_r;
  assign swap_ack = swap_ack_r;
  assign busy     = busy_r;
  assign front    = front_r;

endmodule

// File: tb/tb_vidbuf_dbl.sv
// Directed bench for vidbuf_dbl: a 16x8 1:1 instance and a 2x-scaled
// instance share all inputs; each task checks one scenario inline.
module tb_vidbuf_dbl;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [9:0]  ROW = 10'd0;
  logic [10:0] COL = 11'd0;
  logic [3:0]  wr_x = 4'd0;
  logic [2:0]  wr_y = 3'd0;
  logic [23:0] wr_data = 24'd0;
  logic        wr_valid = 1'b0;
  logic        clr_req = 1'b0;
  logic [23:0] clr_data = 24'd0;
  logic        swap_req = 1'b0;

  logic [7:0]  r0, g0, b0, r1, g1, b1;
  logic        wr_ready0, swap_ack0, busy0, front0;
  logic        wr_ready1, swap_ack1, busy1, front1;

  int checks = 0;
  int errors = 0;

  vidbuf_dbl #(.X_W(4), .Y_W(3), .PIX_W(24), .COL_W(11), .ROW_W(10),
               .SCALE(0), .BORDER(24'h123456)) dut0 (
    .CLK(CLK), .RST(RST), .ROW(ROW), .COL(COL), .R(r0), .G(g0), .B(b0),
    .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready0), .clr_req(clr_req), .clr_data(clr_data),
    .swap_req(swap_req), .swap_ack(swap_ack0), .busy(busy0), .front(front0));

  vidbuf_dbl #(.X_W(4), .Y_W(3), .PIX_W(24), .COL_W(11), .ROW_W(10),
               .SCALE(1), .BORDER(24'h123456)) dut1 (
    .CLK(CLK), .RST(RST), .ROW(ROW), .COL(COL), .R(r1), .G(g1), .B(b1),
    .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready1), .clr_req(clr_req), .clr_data(clr_data),
    .swap_req(swap_req), .swap_ack(swap_ack1), .busy(busy1), .front(front1));

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    tick();
    tick();
    checks++;
    if ({r0, g0, b0, busy0, front0, wr_ready0, swap_ack0} !== 28'd0) begin
      errors++;
      $display("FAIL reset_state got %h exp 0", {r0, g0, b0, busy0, front0, wr_ready0, swap_ack0});
    end
    RST = 1'b1;
    ROW = 10'd9;
    COL = 11'd20;
    #2;
    checks++;
    if (wr_ready0 !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_clk got %b exp 0", wr_ready0);
    end
    tick();
    checks++;
    if (wr_ready0 !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_clk got %b exp 1", wr_ready0);
    end
    tick();
    checks++;
    if ({r0, g0, b0} !== 24'h123456 || front0 !== 1'b0) begin
      errors++;
      $display("FAIL border got %h front %b exp 123456 front 0", {r0, g0, b0}, front0);
    end
  endtask

  task automatic test_write_swap();
    wr_x = 4'd3; wr_y = 3'd2; wr_data = 24'hFF0000; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    swap_req = 1'b1;
    ROW = 10'd5; COL = 11'd5;
    tick();
    swap_req = 1'b0;
    checks++;
    if ({busy0, wr_ready0, front0, swap_ack0} !== 4'b1000) begin
      errors++;
      $display("FAIL swap_wait_status got %b exp 1000", {busy0, wr_ready0, front0, swap_ack0});
    end
    tick();
    checks++;
    if (front0 !== 1'b0 || swap_ack0 !== 1'b0) begin
      errors++;
      $display("FAIL swap_early got front %b ack %b exp 0 0", front0, swap_ack0);
    end
    ROW = 10'd0; COL = 11'd0;
    tick();
    checks++;
    if (swap_ack0 !== 1'b1 || front0 !== 1'b1) begin
      errors++;
      $display("FAIL swap_take got ack %b front %b exp 1 1", swap_ack0, front0);
    end
    ROW = 10'd2; COL = 11'd3;
    tick();
    checks++;
    if (swap_ack0 !== 1'b0 || wr_ready0 !== 1'b1) begin
      errors++;
      $display("FAIL swap_ack_pulse got ack %b ready %b exp 0 1", swap_ack0, wr_ready0);
    end
    tick();
    checks++;
    if ({r0, g0, b0} !== 24'hFF0000) begin
      errors++;
      $display("FAIL written_pixel got %h exp ff0000", {r0, g0, b0});
    end
  endtask

  task automatic test_clear();
    int n = 0;
    int ready_bad = 0;
    int pix_bad = 0;
    ROW = 10'd5; COL = 11'd5;
    clr_data = 24'h00FF00; clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    while (busy0 === 1'b1 && n < 300) begin
      if (wr_ready0 !== 1'b0) ready_bad++;
      swap_req = (n == 10);
      n++;
      tick();
    end
    swap_req = 1'b0;
    checks++;
    if (n !== 128) begin
      errors++;
      $display("FAIL clear_cycles got %0d exp 128", n);
    end
    checks++;
    if (ready_bad !== 0 || wr_ready0 !== 1'b1) begin
      errors++;
      $display("FAIL clear_ready got bad %0d ready %b exp 0 1", ready_bad, wr_ready0);
    end
    swap_req = 1'b1; ROW = 10'd0; COL = 11'd0;
    tick();
    swap_req = 1'b0;
    tick();
    checks++;
    if (front0 !== 1'b0 || swap_ack0 !== 1'b1) begin
      errors++;
      $display("FAIL clear_swap got front %b ack %b exp 0 1", front0, swap_ack0);
    end
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 16; c++) begin
        ROW = 10'(r); COL = 11'(c);
        tick();
        tick();
        checks++;
        if ({r0, g0, b0} !== 24'h00FF00) begin
          errors++;
          pix_bad++;
          if (pix_bad < 4) $display("FAIL clear_pixel r%0d c%0d got %h exp 00ff00", r, c, {r0, g0, b0});
        end
      end
    end
  endtask

  task automatic test_clr_swap();
    int n = 1;
    int busy_bad = 0;
    ROW = 10'd0; COL = 11'd0;
    clr_data = 24'h0000FF; clr_req = 1'b1; swap_req = 1'b1;
    tick();
    clr_req = 1'b0; swap_req = 1'b0;
    while (swap_ack0 !== 1'b1 && n < 400) begin
      if (busy0 !== 1'b1) busy_bad++;
      n++;
      tick();
    end
    checks++;
    if (n !== 130) begin
      errors++;
      $display("FAIL clr_swap_ack_cycle got %0d exp 130", n);
    end
    checks++;
    if (busy_bad !== 0 || front0 !== 1'b1) begin
      errors++;
      $display("FAIL clr_swap_state got busy_bad %0d front %b exp 0 1", busy_bad, front0);
    end
    ROW = 10'd2; COL = 11'd3;
    tick();
    tick();
    checks++;
    if ({r0, g0, b0} !== 24'h0000FF) begin
      errors++;
      $display("FAIL clr_swap_pixel got %h exp 0000ff", {r0, g0, b0});
    end
  endtask

  task automatic test_scale();
    logic [10:0] cs [4] = '{11'd2, 11'd3, 11'd2, 11'd3};
    logic [9:0]  rs [4] = '{10'd2, 10'd2, 10'd3, 10'd3};
    wr_x = 4'd1; wr_y = 3'd1; wr_data = 24'hABCDEF; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    swap_req = 1'b1; ROW = 10'd0; COL = 11'd0;
    tick();
    swap_req = 1'b0;
    tick();
    checks++;
    if (front1 !== 1'b0) begin
      errors++;
      $display("FAIL scale_front got %b exp 0", front1);
    end
    for (int i = 0; i < 4; i++) begin
      ROW = rs[i]; COL = cs[i];
      tick();
      tick();
      checks++;
      if ({r1, g1, b1} !== 24'hABCDEF) begin
        errors++;
        $display("FAIL scale_pixel c%0d r%0d got %h exp abcdef", cs[i], rs[i], {r1, g1, b1});
      end
    end
    ROW = 10'd2; COL = 11'd4;
    tick();
    tick();
    checks++;
    if ({r1, g1, b1} !== 24'h00FF00) begin
      errors++;
      $display("FAIL scale_neighbour got %h exp 00ff00", {r1, g1, b1});
    end
    ROW = 10'd1; COL = 11'd1;
    tick();
    tick();
    checks++;
    if ({r0, g0, b0} !== 24'hABCDEF) begin
      errors++;
      $display("FAIL unscaled_pixel got %h exp abcdef", {r0, g0, b0});
    end
    ROW = 10'd0; COL = 11'd32;
    tick();
    tick();
    checks++;
    if ({r1, g1, b1} !== 24'h123456) begin
      errors++;
      $display("FAIL scale_border got %h exp 123456", {r1, g1, b1});
    end
  endtask

  task automatic test_reset_mid_clear();
    swap_req = 1'b1; ROW = 10'd0; COL = 11'd0;
    tick();
    swap_req = 1'b0;
    tick();
    ROW = 10'd9; COL = 11'd20;
    clr_data = 24'hFFFFFF; clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    checks++;
    if ({busy0, front0, r0, g0, b0} !== {2'b11, 24'h123456}) begin
      errors++;
      $display("FAIL pre_reset got busy %b front %b rgb %h exp 1 1 123456", busy0, front0, {r0, g0, b0});
    end
    #2;
    RST = 1'b0;
    #1;
    checks++;
    if ({busy0, front0, wr_ready0, r0, g0, b0} !== 27'd0) begin
      errors++;
      $display("FAIL async_reset got busy %b front %b ready %b rgb %h exp all 0",
               busy0, front0, wr_ready0, {r0, g0, b0});
    end
    tick();
    RST = 1'b1;
    #1;
    checks++;
    if (wr_ready0 !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_ready_early got %b exp 0", wr_ready0);
    end
    tick();
    checks++;
    if (wr_ready0 !== 1'b1 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_idle got ready %b busy %b exp 1 0", wr_ready0, busy0);
    end
  endtask

  initial begin
    test_reset();
    test_write_swap();
    test_clear();
    test_clr_swap();
    test_scale();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
